// File: rtl/figure_selector_pkg.sv
// Shared figure indices, FSM state type and grid arithmetic helpers for figure_selector.
`default_nettype none

package figure_selector_pkg;

  localparam int GRID_DIM  = 3;
  localparam int NUM_FIGS  = GRID_DIM * GRID_DIM;
  localparam int DBC_CNT_W = 20;
  localparam int NUM_BTNS  = 5;

  localparam logic [3:0] FIG_CIRCLE    = 4'd0;
  localparam logic [3:0] FIG_SQUARE    = 4'd1;
  localparam logic [3:0] FIG_TRIANGLE  = 4'd2;
  localparam logic [3:0] FIG_OVAL      = 4'd3;
  localparam logic [3:0] FIG_RECTANGLE = 4'd4;
  localparam logic [3:0] FIG_DIAMOND   = 4'd5;
  localparam logic [3:0] FIG_HEXAGON   = 4'd6;
  localparam logic [3:0] FIG_PENTAGON  = 4'd7;
  localparam logic [3:0] FIG_STAR      = 4'd8;

  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_UP    = 3;
  localparam int BTN_ENTER = 4;

  typedef enum logic [0:0] {
    BROWSE = 1'b0,
    FULL   = 1'b1
  } state_t;

  function automatic logic [1:0] wrap_inc(input logic [1:0] v);
    return (v == 2'(GRID_DIM - 1)) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic [1:0] wrap_dec(input logic [1:0] v);
    return (v == 2'd0) ? 2'(GRID_DIM - 1) : v - 2'd1;
  endfunction

  function automatic logic [3:0] fig_index(input logic [1:0] row, input logic [1:0] col);
    return ({2'b00, row} * 4'(GRID_DIM)) + {2'b00, col};
  endfunction

  function automatic logic [NUM_FIGS-1:0] fig_decode(input logic [3:0] idx);
    return NUM_FIGS'(1) << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, counting debouncer and press-edge detector for one push-button.
`default_nettype none

module button_debouncer
  import figure_selector_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam logic [DBC_CNT_W-1:0] LAST = DBC_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                 sync_a;
  logic                 sync_b;
  logic                 level;
  logic [DBC_CNT_W-1:0] count;
  logic                 accept;

  // The count tracks how long the synchronized level has disagreed with the accepted one.
  assign accept = (sync_b != level) && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      level  <= 1'b0;
      count  <= '0;
      press  <= 1'b0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
      press  <= accept & sync_b;
      if (sync_b == level) begin
        count <= '0;
      end else if (accept) begin
        count <= '0;
        level <= sync_b;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/figure_selector.sv
// Debounced 3x3 figure-grid cursor with browse / full-screen modes and registered one-hot select.
`default_nettype none

module figure_selector
  import figure_selector_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_enter,
  output logic       circle_select,
  output logic       square_select,
  output logic       triangle_select,
  output logic       oval_select,
  output logic       rectangle_select,
  output logic       diamond_select,
  output logic       hexagon_select,
  output logic       pentagon_select,
  output logic       star_select,
  output logic       full_screen,
  output logic [3:0] cursor
);

  logic [NUM_BTNS-1:0] raw;
  logic [NUM_BTNS-1:0] press;

  assign raw[BTN_RIGHT] = btn_right;
  assign raw[BTN_LEFT]  = btn_left;
  assign raw[BTN_DOWN]  = btn_down;
  assign raw[BTN_UP]    = btn_up;
  assign raw[BTN_ENTER] = btn_enter;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_dbc (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_raw(raw[i]),
      .press  (press[i])
    );
  end

  state_t              state;
  state_t              state_nx;
  logic [1:0]          row;
  logic [1:0]          col;
  logic [1:0]          row_nx;
  logic [1:0]          col_nx;
  logic [NUM_FIGS-1:0] sel;

  // Priority chain: enter > up > down > left > right; arrows are dead in FULL.
  always_comb begin
    state_nx = state;
    row_nx   = row;
    col_nx   = col;
    if (press[BTN_ENTER]) begin
      state_nx = (state == BROWSE) ? FULL : BROWSE;
    end else if (state == BROWSE) begin
      if (press[BTN_UP]) begin
        row_nx = wrap_dec(row);
      end else if (press[BTN_DOWN]) begin
        row_nx = wrap_inc(row);
      end else if (press[BTN_LEFT]) begin
        col_nx = wrap_dec(col);
      end else if (press[BTN_RIGHT]) begin
        col_nx = wrap_inc(col);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BROWSE;
      row         <= 2'd0;
      col         <= 2'd0;
      cursor      <= FIG_CIRCLE;
      sel         <= fig_decode(FIG_CIRCLE);
      full_screen <= 1'b0;
    end else begin
      state       <= state_nx;
      row         <= row_nx;
      col         <= col_nx;
      cursor      <= fig_index(row_nx, col_nx);
      sel         <= fig_decode(fig_index(row_nx, col_nx));
      full_screen <= (state_nx == FULL);
    end
  end

  assign circle_select    = sel[FIG_CIRCLE];
  assign square_select    = sel[FIG_SQUARE];
  assign triangle_select  = sel[FIG_TRIANGLE];
  assign oval_select      = sel[FIG_OVAL];
  assign rectangle_select = sel[FIG_RECTANGLE];
  assign diamond_select   = sel[FIG_DIAMOND];
  assign hexagon_select   = sel[FIG_HEXAGON];
  assign pentagon_select  = sel[FIG_PENTAGON];
  assign star_select      = sel[FIG_STAR];

endmodule

`default_nettype wire

// File: doc/figure_selector.md
FIGURE_SELECTOR -- requirements
Module: figure_selector

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable synchronized cycles required to accept a button level (legal range 2..2^20-1).
REQ-002 The block SHALL have port clk, input, 1, single system clock; all state SHALL be clocked on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports btn_up, btn_down, btn_left, btn_right, btn_enter, each input, 1, raw asynchronous active-high push-buttons.
REQ-005 The block SHALL have ports circle_select, square_select, triangle_select, oval_select, rectangle_select, diamond_select, hexagon_select, pentagon_select, star_select, each output, 1, one-hot figure select to the drawing datapath.
REQ-006 The block SHALL have port full_screen, output, 1, high while the selected figure is shown enlarged.
REQ-007 The block SHALL have port cursor, output, 4, current figure index 0..8.

Function
REQ-008 Each button SHALL pass a 2-flop synchronizer, then a debouncer whose accepted level changes only after DEBOUNCE_CYCLES consecutive cycles of the new synchronized level; any bounce restarts the count.
REQ-009 Each debouncer SHALL emit a one-cycle press pulse on an accepted 0->1 transition only; releases SHALL produce no pulse, and a held button SHALL produce exactly one pulse.
REQ-010 Index map (row-major 3x3 grid): 0 circle, 1 square, 2 triangle, 3 oval, 4 rectangle, 5 diamond, 6 hexagon, 7 pentagon, 8 star; row = index/3, col = index%3.
REQ-011 The FSM SHALL have states BROWSE and FULL; full_screen SHALL be 1 exactly in FULL.
REQ-012 In BROWSE: right pulse col = (col+1) mod 3; left pulse col = (col+2) mod 3; down pulse row = (row+1) mod 3; up pulse row = (row+2) mod 3; the other coordinate SHALL be unchanged.
REQ-013 In BROWSE an enter pulse SHALL move the FSM to FULL with cursor unchanged.
REQ-014 In FULL, up/down/left/right pulses SHALL be ignored; an enter pulse SHALL return the FSM to BROWSE with cursor unchanged.
REQ-015 When several pulses occur in one cycle, only the highest priority SHALL act: enter > up > down > left > right.
REQ-016 All outputs SHALL be registered; an action caused by a pulse in cycle N SHALL be visible on the outputs in cycle N+1.
REQ-017 Exactly one select output SHALL be high at every cycle, equal to the decode of cursor.
REQ-018 cursor SHALL never take values 9..15; arithmetic SHALL use 2-bit row/col with explicit wrap, not 4-bit index increments.

Reset
REQ-019 rst_n low SHALL immediately set cursor=0, circle_select=1, all other selects=0, full_screen=0, state=BROWSE, debouncer accepted levels=0, counters=0, synchronizers=0.
REQ-020 Reset asserted mid-debounce or in FULL SHALL discard the pending press; a button still held after rst_n release SHALL be accepted only after a full DEBOUNCE_CYCLES window and then produce one pulse.

Structure
REQ-021 A shared package SHALL hold figure index constants (FIG_CIRCLE..FIG_STAR), the state type {BROWSE, FULL}, and the grid dimension constant 3.
REQ-022 Synchronizer plus debouncer plus edge detector SHALL be one sub-module, button_debouncer, instantiated five times with DEBOUNCE_CYCLES passed through.
REQ-023 Decode of cursor to the nine selects SHALL be registered in figure_selector, not in the sub-module.

Verification (DEBOUNCE_CYCLES=4)
REQ-024 Reset, no buttons -> cursor=0, circle_select=1, full_screen=0.
REQ-025 From cursor 2 (triangle), clean right press -> cursor=0; from cursor 0, up press -> cursor=6 (hexagon).
REQ-026 btn_right toggling every 2 cycles for 20 cycles, then stable high 10 cycles -> exactly one move, cursor 0->1.
REQ-027 At cursor 4, enter press -> full_screen=1, rectangle_select=1; then left press -> no change; then enter -> full_screen=0, cursor=4.
REQ-028 btn_enter and btn_down accepted in same cycle at cursor 1 -> FULL entered, cursor stays 1.
REQ-029 rst_n pulsed low while in FULL at cursor 8 -> asynchronous return to cursor=0, full_screen=0 before next clock edge.
